// File: rtl/stream_arbiter_3to1_if.sv
// Purpose : bundles the three request ports, the arbitrated output port and the grant outputs of the 3:1 AXI address arbiter.
// Latency : wires only.
// Backpressure: carries io_output_ready downstream-to-upstream and the per-input readies from the arbiter.
//
// Modports:
//   slave  - the arbiter's view: samples request valids/payloads and io_output_ready,
//            drives input readies, the output request and the grant (io_chosen/io_chosenOH).
//   master - the surrounding fabric's view: the mirror image of slave.
interface stream_arbiter_3to1_if;

    // Input 0
    logic        io_inputs_0_valid;
    logic        io_inputs_0_ready;
    logic [19:0] io_inputs_0_payload_addr;
    logic [3:0]  io_inputs_0_payload_id;
    logic [7:0]  io_inputs_0_payload_len;
    logic [2:0]  io_inputs_0_payload_size;
    logic [1:0]  io_inputs_0_payload_burst;

    // Input 1
    logic        io_inputs_1_valid;
    logic        io_inputs_1_ready;
    logic [19:0] io_inputs_1_payload_addr;
    logic [3:0]  io_inputs_1_payload_id;
    logic [7:0]  io_inputs_1_payload_len;
    logic [2:0]  io_inputs_1_payload_size;
    logic [1:0]  io_inputs_1_payload_burst;

    // Input 2
    logic        io_inputs_2_valid;
    logic        io_inputs_2_ready;
    logic [19:0] io_inputs_2_payload_addr;
    logic [3:0]  io_inputs_2_payload_id;
    logic [7:0]  io_inputs_2_payload_len;
    logic [2:0]  io_inputs_2_payload_size;
    logic [1:0]  io_inputs_2_payload_burst;

    // Arbitrated output
    logic        io_output_valid;
    logic        io_output_ready;
    logic [19:0] io_output_payload_addr;
    logic [3:0]  io_output_payload_id;
    logic [7:0]  io_output_payload_len;
    logic [2:0]  io_output_payload_size;
    logic [1:0]  io_output_payload_burst;

    // Grant, for routing the matching response/data path
    logic [1:0]  io_chosen;
    logic [2:0]  io_chosenOH;

    modport slave (
        input  io_inputs_0_valid, io_inputs_0_payload_addr, io_inputs_0_payload_id,
               io_inputs_0_payload_len, io_inputs_0_payload_size, io_inputs_0_payload_burst,
        input  io_inputs_1_valid, io_inputs_1_payload_addr, io_inputs_1_payload_id,
               io_inputs_1_payload_len, io_inputs_1_payload_size, io_inputs_1_payload_burst,
        input  io_inputs_2_valid, io_inputs_2_payload_addr, io_inputs_2_payload_id,
               io_inputs_2_payload_len, io_inputs_2_payload_size, io_inputs_2_payload_burst,
        output io_inputs_0_ready, io_inputs_1_ready, io_inputs_2_ready,
        output io_output_valid, io_output_payload_addr, io_output_payload_id,
               io_output_payload_len, io_output_payload_size, io_output_payload_burst,
        input  io_output_ready,
        output io_chosen, io_chosenOH
    );

    modport master (
        output io_inputs_0_valid, io_inputs_0_payload_addr, io_inputs_0_payload_id,
               io_inputs_0_payload_len, io_inputs_0_payload_size, io_inputs_0_payload_burst,
        output io_inputs_1_valid, io_inputs_1_payload_addr, io_inputs_1_payload_id,
               io_inputs_1_payload_len, io_inputs_1_payload_size, io_inputs_1_payload_burst,
        output io_inputs_2_valid, io_inputs_2_payload_addr, io_inputs_2_payload_id,
               io_inputs_2_payload_len, io_inputs_2_payload_size, io_inputs_2_payload_burst,
        input  io_inputs_0_ready, io_inputs_1_ready, io_inputs_2_ready,
        input  io_output_valid, io_output_payload_addr, io_output_payload_id,
               io_output_payload_len, io_output_payload_size, io_output_payload_burst,
        output io_output_ready,
        input  io_chosen, io_chosenOH
    );

endinterface

// File: rtl/stream_arbiter_3to1.sv
// Purpose : 3:1 round-robin arbiter for AXI AW/AR requests; grant is held (locked) until the output handshake completes.
// Latency : zero; the granted request passes combinationally and is accepted in the cycle it is presented.
// Backpressure: io_output_ready is steered to the granted input only; a stalled grant is frozen until it fires.
//
// Ports:
//   clk    - clock, all state on the rising edge
//   reset  - asynchronous, active-high
//   io     - stream_arbiter_3to1_if.slave: three request inputs, one output, io_chosen / io_chosenOH
module stream_arbiter_3to1 (
    input  logic                   clk,
    input  logic                   reset,
    stream_arbiter_3to1_if.slave   io
);

    typedef struct packed {
        logic [19:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } payload_t;

    // OPEN: the grant follows the round-robin proposal each cycle.
    // LOCKED: a presented request stalled, so the grant is pinned to mask_locked.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] mask_locked;     // last granted input, one-hot
    logic [2:0] mask_locked_nxt;

    logic [2:0] in_valid;
    payload_t   in_payload_0;
    payload_t   in_payload_1;
    payload_t   in_payload_2;

    logic [1:0] rr_start;
    logic [2:0] proposal;
    logic [2:0] routed;
    logic [1:0] chosen;
    logic       out_valid;
    logic       fire;
    payload_t   out_payload;

    // (a + b) mod 3 for a, b in 0..2
    function automatic logic [1:0] wrap3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    assign in_valid = {io.io_inputs_2_valid, io.io_inputs_1_valid, io.io_inputs_0_valid};

    assign in_payload_0 = {io.io_inputs_0_payload_addr, io.io_inputs_0_payload_id,
                           io.io_inputs_0_payload_len, io.io_inputs_0_payload_size,
                           io.io_inputs_0_payload_burst};
    assign in_payload_1 = {io.io_inputs_1_payload_addr, io.io_inputs_1_payload_id,
                           io.io_inputs_1_payload_len, io.io_inputs_1_payload_size,
                           io.io_inputs_1_payload_burst};
    assign in_payload_2 = {io.io_inputs_2_payload_addr, io.io_inputs_2_payload_id,
                           io.io_inputs_2_payload_len, io.io_inputs_2_payload_size,
                           io.io_inputs_2_payload_burst};

    // Search starts one past the last granted input. The reset value 3'b100
    // therefore gives input 0 first priority.
    always_comb begin
        rr_start = 2'd0;
        case (mask_locked)
            3'b001:  rr_start = 2'd1;
            3'b010:  rr_start = 2'd2;
            default: rr_start = 2'd0;
        endcase
    end

    // First valid input found walking upward from rr_start with wrap.
    always_comb begin
        logic [1:0] idx;
        proposal = 3'b000;
        idx      = 2'd0;
        for (int k = 0; k < 3; k++) begin
            idx = wrap3(rr_start, k[1:0]);
            if ((proposal == 3'b000) && in_valid[idx]) begin
                proposal[idx] = 1'b1;
            end
        end
    end

    assign routed = (state == ST_LOCKED) ? mask_locked : proposal;

    always_comb begin
        chosen = 2'd0;
        case (routed)
            3'b010:  chosen = 2'd1;
            3'b100:  chosen = 2'd2;
            default: chosen = 2'd0;
        endcase
    end

    // A locked input that drops valid shows as an invalid output; the lock
    // itself is untouched until that input fires.
    assign out_valid = |(in_valid & routed);
    assign fire      = out_valid & io.io_output_ready;

    // Idle output (routed == 0) reflects input 0's payload.
    always_comb begin
        out_payload = in_payload_0;
        case (chosen)
            2'd1:    out_payload = in_payload_1;
            2'd2:    out_payload = in_payload_2;
            default: out_payload = in_payload_0;
        endcase
    end

    // Grant FSM: a fire releases the lock and records the winner for the next
    // round-robin search; a stall pins the current winner.
    always_comb begin
        state_nxt       = state;
        mask_locked_nxt = mask_locked;
        if (fire) begin
            state_nxt       = ST_OPEN;
            mask_locked_nxt = routed;
        end else if (out_valid) begin
            state_nxt       = ST_LOCKED;
            mask_locked_nxt = routed;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_OPEN;
            mask_locked <= 3'b100;
        end else begin
            state       <= state_nxt;
            mask_locked <= mask_locked_nxt;
        end
    end

    assign io.io_inputs_0_ready = io.io_output_ready & routed[0];
    assign io.io_inputs_1_ready = io.io_output_ready & routed[1];
    assign io.io_inputs_2_ready = io.io_output_ready & routed[2];

    assign io.io_output_valid         = out_valid;
    assign io.io_output_payload_addr  = out_payload.addr;
    assign io.io_output_payload_id    = out_payload.id;
    assign io.io_output_payload_len   = out_payload.len;
    assign io.io_output_payload_size  = out_payload.size;
    assign io.io_output_payload_burst = out_payload.burst;

    assign io.io_chosen   = chosen;
    assign io.io_chosenOH = routed;

endmodule

// File: tb/tb_stream_arbiter_3to1.sv
// Purpose : directed bench for stream_arbiter_3to1 with a fire scoreboard.
// Latency : expects zero-latency grant/handshake.
// Backpressure: drives io_output_ready low/pulsed/continuous to exercise locking and round robin.
module tb_stream_arbiter_3to1;

    logic clk;
    logic reset;

    stream_arbiter_3to1_if bus ();

    stream_arbiter_3to1 dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  chosen;
        logic [3:0]  id;
        logic [19:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_fires = 0;

    function automatic logic [19:0] addr_of(input int n);
        return 20'h00105 + 20'(n) * 20'h01110;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int n, input logic v);
        case (n)
            0:       bus.io_inputs_0_valid = v;
            1:       bus.io_inputs_1_valid = v;
            default: bus.io_inputs_2_valid = v;
        endcase
    endtask

    task automatic set_all(input logic v);
        for (int n = 0; n < 3; n++) set_in(n, v);
    endtask

    task automatic push(input int n);
        exp_t e;
        e.chosen = 2'(n);
        e.id     = 4'(n);
        e.addr   = addr_of(n);
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] oh,
                             input logic [1:0] ch, input logic [2:0] rdy);
        logic [2:0] rdy_obs;
        rdy_obs = {bus.io_inputs_2_ready, bus.io_inputs_1_ready, bus.io_inputs_0_ready};
        chk({tag, ".valid"},    32'(bus.io_output_valid), 32'(v));
        chk({tag, ".chosenOH"}, 32'(bus.io_chosenOH),     32'(oh));
        chk({tag, ".chosen"},   32'(bus.io_chosen),       32'(ch));
        chk({tag, ".ready"},    32'(rdy_obs),             32'(rdy));
        if (v) begin
            chk({tag, ".id"},   32'(bus.io_output_payload_id),   32'(ch));
            chk({tag, ".addr"}, 32'(bus.io_output_payload_addr), 32'(addr_of(int'(ch))));
        end
    endtask

    // Scoreboard: every handshake on the output must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.io_output_valid && bus.io_output_ready) begin
            n_fires++;
            chk("sb.expected_fire", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb.chosen", 32'(bus.io_chosen),              32'(e.chosen));
                chk("sb.id",     32'(bus.io_output_payload_id),   32'(e.id));
                chk("sb.addr",   32'(bus.io_output_payload_addr), 32'(e.addr));
                chk("sb.len",    32'(bus.io_output_payload_len),  32'd255);
                chk("sb.size",   32'(bus.io_output_payload_size), 32'd2);
                chk("sb.burst",  32'(bus.io_output_payload_burst), 32'd1);
            end
        end
    end

    initial begin
        logic [2:0] oh;
        int         e;

        reset = 1'b1;
        bus.io_output_ready = 1'b0;
        set_all(1'b0);
        bus.io_inputs_0_payload_addr = addr_of(0);
        bus.io_inputs_1_payload_addr = addr_of(1);
        bus.io_inputs_2_payload_addr = addr_of(2);
        bus.io_inputs_0_payload_id = 4'd0;
        bus.io_inputs_1_payload_id = 4'd1;
        bus.io_inputs_2_payload_id = 4'd2;
        bus.io_inputs_0_payload_len = 8'd255;
        bus.io_inputs_1_payload_len = 8'd255;
        bus.io_inputs_2_payload_len = 8'd255;
        bus.io_inputs_0_payload_size = 3'd2;
        bus.io_inputs_1_payload_size = 3'd2;
        bus.io_inputs_2_payload_size = 3'd2;
        bus.io_inputs_0_payload_burst = 2'd1;
        bus.io_inputs_1_payload_burst = 2'd1;
        bus.io_inputs_2_payload_burst = 2'd1;

        // Reset, idle inputs
        #3;
        check_out("rst_hold", 1'b0, 3'b000, 2'd0, 3'b000);
        next_cycle();
        reset = 1'b0;
        #2;
        check_out("rst_idle", 1'b0, 3'b000, 2'd0, 3'b000);

        // All valid, ready low for 10 cycles: input 0 granted and held
        next_cycle();
        set_all(1'b1);
        #2;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                next_cycle();
                #2;
            end
            check_out("hold0", 1'b1, 3'b001, 2'd0, 3'b000);
        end

        // Three single-cycle ready pulses, each winner drops valid afterwards
        for (int n = 0; n < 3; n++) begin
            next_cycle();
            bus.io_output_ready = 1'b1;
            push(n);
            #2;
            oh = 3'b001 << n;
            check_out("pulse", 1'b1, oh, 2'(n), oh);
            next_cycle();
            bus.io_output_ready = 1'b0;
            set_in(n, 1'b0);
            #2;
            if (n < 2) begin
                oh = 3'b001 << (n + 1);
                check_out("after_pulse", 1'b1, oh, 2'(n + 1), 3'b000);
            end else begin
                check_out("drained", 1'b0, 3'b000, 2'd0, 3'b000);
            end
        end

        // Lock on input 2, then input 0 arrives and must wait
        next_cycle();
        set_in(2, 1'b1);
        #2;
        check_out("lock2", 1'b1, 3'b100, 2'd2, 3'b000);
        next_cycle();
        set_in(0, 1'b1);
        #2;
        check_out("lock2_hold", 1'b1, 3'b100, 2'd2, 3'b000);
        next_cycle();
        #2;
        check_out("lock2_hold2", 1'b1, 3'b100, 2'd2, 3'b000);
        next_cycle();
        bus.io_output_ready = 1'b1;
        push(2);
        #2;
        check_out("lock2_fire", 1'b1, 3'b100, 2'd2, 3'b100);
        next_cycle();
        bus.io_output_ready = 1'b0;
        set_in(2, 1'b0);
        #2;
        check_out("next_is_0", 1'b1, 3'b001, 2'd0, 3'b000);

        // Locked input 0 illegally drops valid: output invalid, lock persists
        next_cycle();
        set_in(0, 1'b0);
        set_in(1, 1'b1);
        #2;
        check_out("drop_locked", 1'b0, 3'b001, 2'd0, 3'b000);
        next_cycle();
        #2;
        check_out("drop_locked2", 1'b0, 3'b001, 2'd0, 3'b000);

        // Continuous ready with all valid: 0,1,2,0,1,2 one per cycle
        next_cycle();
        set_all(1'b1);
        bus.io_output_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e = k % 3;
            push(e);
            #2;
            oh = 3'b001 << e;
            check_out("rr", 1'b1, oh, 2'(e), oh);
            next_cycle();
        end

        // One more fire of input 0, then stall to lock on input 1
        push(0);
        #2;
        check_out("rr_wrap", 1'b1, 3'b001, 2'd0, 3'b001);
        next_cycle();
        bus.io_output_ready = 1'b0;
        #2;
        check_out("lock1", 1'b1, 3'b010, 2'd1, 3'b000);
        next_cycle();
        #2;
        check_out("lock1_hold", 1'b1, 3'b010, 2'd1, 3'b000);

        // Asynchronous reset while locked on input 1
        reset = 1'b1;
        #1;
        check_out("rst_mid", 1'b1, 3'b001, 2'd0, 3'b000);
        next_cycle();
        reset = 1'b0;
        #2;
        check_out("post_rst", 1'b1, 3'b001, 2'd0, 3'b000);

        next_cycle();
        set_all(1'b0);
        #2;
        check_out("end", 1'b0, 3'b001, 2'd0, 3'b000);

        next_cycle();
        chk("fire_count", 32'(n_fires), 32'd11);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
